// File: rtl/fifo_burst_reader_if.sv
// FIFO read-port and output-stream signal bundle for fifo_burst_reader.
// master = the burst reader, slave = the surrounding FIFO and stream sink.
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 18
);
  logic                  fifo_empty_i;
  logic                  fifo_rd_o;
  logic                  fifo_oe_o;
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_last_o;

  modport master (
    input  fifo_empty_i, fifo_data_i, m_ready_i,
    output fifo_rd_o, fifo_oe_o, m_valid_o, m_data_o, m_last_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, m_ready_i,
    input  fifo_rd_o, fifo_oe_o, m_valid_o, m_data_o, m_last_o
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a fixed-length burst from a synchronous FIFO into a valid/ready stream,
// absorbing the FIFO read latency in a credit-limited 2-entry buffer.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 18,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] burst_len_i,
  input  logic                 abort_i,
  fifo_burst_reader_if.master  bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 aborted_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic                  aborted_q, aborted_d;
  logic [LEN_WIDTH-1:0]  len_q, issued_q, sent_q;
  logic                  vld_p1;
  logic [1:0]            occ_p2;
  logic                  rd_ptr_p2, wr_ptr_p2;
  logic [DATA_WIDTH-1:0] mem_p2 [2];

  logic active, flush, valid, pop, push, rd, last;

  assign active = (state_q == RUN) || (state_q == DRAIN);
  assign flush  = active && abort_i;
  assign valid  = (occ_p2 != 2'd0);
  assign pop    = valid && bus.m_ready_i;
  assign push   = vld_p1 && !flush;
  assign last   = valid && (sent_q == len_q - LEN_WIDTH'(1));

  // Credit check: words buffered plus in flight, net of this cycle's pop, must leave a free slot.
  assign rd = (state_q == RUN) && !bus.fifo_empty_i && !abort_i && (issued_q < len_q) &&
              (({1'b0, occ_p2} + {2'b00, vld_p1}) < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_d   = state_q;
    aborted_d = aborted_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          aborted_d = 1'b0;
          state_d   = (burst_len_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (rd && (issued_q + LEN_WIDTH'(1) == len_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort_i) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (pop && last) begin
          state_d   = DONE;
          aborted_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      aborted_q <= 1'b0;
      len_q     <= '0;
      issued_q  <= '0;
      sent_q    <= '0;
    end else begin
      state_q   <= state_d;
      aborted_q <= aborted_d;
      if (state_q == IDLE) begin
        issued_q <= '0;
        sent_q   <= '0;
        if (start_i) len_q <= burst_len_i;
      end else begin
        if (rd)  issued_q <= issued_q + LEN_WIDTH'(1);
        if (pop) sent_q   <= sent_q + LEN_WIDTH'(1);
      end
    end
  end

  // Stage p1: FIFO word in flight, valid the cycle after the read strobe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) vld_p1 <= 1'b0;
    else          vld_p1 <= rd && !flush;
  end

  // Stage p2: 2-entry output buffer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      occ_p2    <= 2'd0;
      rd_ptr_p2 <= 1'b0;
      wr_ptr_p2 <= 1'b0;
    end else if (flush) begin
      occ_p2    <= 2'd0;
      rd_ptr_p2 <= 1'b0;
      wr_ptr_p2 <= 1'b0;
    end else begin
      occ_p2 <= occ_p2 + {1'b0, push} - {1'b0, pop};
      if (push) wr_ptr_p2 <= ~wr_ptr_p2;
      if (pop)  rd_ptr_p2 <= ~rd_ptr_p2;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_p2[wr_ptr_p2] <= bus.fifo_data_i;
  end

  assign bus.fifo_rd_o = rd;
  assign bus.fifo_oe_o = (state_q != IDLE);
  assign bus.m_valid_o = valid;
  assign bus.m_data_o  = valid ? mem_p2[rd_ptr_p2] : '0;
  assign bus.m_last_o  = last;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign aborted_o     = (state_q == DONE) && aborted_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized and directed bench for fifo_burst_reader against a queue-based
// reference model of the burst/credit rules, plus literal cycle expectations.
module tb_fifo_burst_reader;
  localparam int DW = 18;
  localparam int LW = 11;
  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_DONE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [LW-1:0] blen = '0;
  logic busy, done, aborted;
  logic force_empty = 1'b0;

  always #5 clk = ~clk;

  fifo_burst_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .burst_len_i(blen),
    .abort_i    (abort),
    .bus        (bus),
    .busy_o     (busy),
    .done_o     (done),
    .aborted_o  (aborted)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // FIFO contents seen by the DUT
  logic [DW-1:0] fq[$];

  // reference model state
  int            m_st = S_IDLE;
  int            m_len = 0, m_iss = 0, m_sent = 0;
  logic          m_infl = 1'b0;
  logic [DW-1:0] m_infl_w = '0;
  logic          m_abt = 1'b0;
  logic [DW-1:0] bq[$];

  int            cyc = 0;
  logic          lg_rd[64], lg_pop[64], lg_last[64], lg_done[64], lg_abt[64];
  logic          lg_valid[64], lg_busy[64];
  logic [DW-1:0] lg_data[64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(DW'(base + i));
  endtask

  // One clock cycle: compare at negedge, advance the model at posedge.
  task automatic step();
    logic e_valid, e_pop, e_rd, e_last, ab;
    logic [DW-1:0] e_data;
    bus.fifo_empty_i = (fq.size() == 0) || force_empty;
    @(negedge clk);
    if (!rst_n) begin
      e_valid = 0; e_pop = 0; e_rd = 0; e_last = 0; e_data = '0;
    end else begin
      e_valid = (bq.size() != 0);
      e_data  = e_valid ? bq[0] : '0;
      e_pop   = e_valid && bus.m_ready_i;
      e_last  = e_valid && (m_sent == m_len - 1);
      e_rd    = (m_st == S_RUN) && !bus.fifo_empty_i && !abort && (m_iss < m_len) &&
                ((bq.size() + int'(m_infl) - int'(e_pop)) < 2);
    end
    chk("fifo_rd", bus.fifo_rd_o, e_rd);
    chk("fifo_oe", bus.fifo_oe_o, rst_n && (m_st != S_IDLE));
    chk("m_valid", bus.m_valid_o, e_valid);
    if (e_valid || !rst_n) chk("m_data", bus.m_data_o, e_data);
    chk("m_last", bus.m_last_o, e_last);
    chk("busy", busy, rst_n && (m_st != S_IDLE));
    chk("done", done, rst_n && (m_st == S_DONE));
    chk("aborted", aborted, rst_n && (m_st == S_DONE) && m_abt);
    if (cyc < 64) begin
      lg_rd[cyc]    = bus.fifo_rd_o;
      lg_pop[cyc]   = bus.m_valid_o && bus.m_ready_i;
      lg_last[cyc]  = bus.m_last_o;
      lg_done[cyc]  = done;
      lg_abt[cyc]   = aborted;
      lg_valid[cyc] = bus.m_valid_o;
      lg_busy[cyc]  = busy;
      lg_data[cyc]  = bus.m_data_o;
    end
    cyc++;
    @(posedge clk);
    if (!rst_n) begin
      m_st = S_IDLE; bq.delete(); m_infl = 0; m_iss = 0; m_sent = 0; m_len = 0; m_abt = 0;
    end else begin
      ab = abort && (m_st == S_RUN || m_st == S_DRAIN);
      if (e_pop) begin
        void'(bq.pop_front());
        m_sent++;
      end
      if (m_infl && !ab) bq.push_back(m_infl_w);
      m_infl = 0;
      if (e_rd) begin
        m_infl   = 1;
        m_infl_w = fq.pop_front();
        m_iss++;
      end
      if (ab) begin
        bq.delete(); m_infl = 0; m_st = S_DONE; m_abt = 1;
      end else if (m_st == S_IDLE) begin
        if (start) begin
          m_len = int'(blen); m_iss = 0; m_sent = 0; m_abt = 0;
          m_st = (blen == '0) ? S_DONE : S_RUN;
        end
      end else if (m_st == S_RUN) begin
        if (e_rd && m_iss == m_len) m_st = S_DRAIN;
      end else if (m_st == S_DRAIN) begin
        if (e_pop && e_last) begin m_st = S_DONE; m_abt = 0; end
      end else begin
        m_st = S_IDLE;
      end
    end
    #1;
    bus.fifo_data_i = e_rd ? m_infl_w : DW'($urandom);
  endtask

  function automatic int count_log(input int kind, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi && i < 64; i++) begin
      case (kind)
        0: n += int'(lg_rd[i]);
        1: n += int'(lg_pop[i]);
        2: n += int'(lg_last[i]);
        3: n += int'(lg_done[i]);
        default: n += int'(lg_valid[i]);
      endcase
    end
    return n;
  endfunction

  initial begin
    int k, pc, ka;
    logic [3:0] pat;
    bus.fifo_empty_i = 1'b1;
    bus.fifo_data_i  = '0;
    bus.m_ready_i    = 1'b0;

    // reset state
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // len=4, ready high
    fq.delete(); load('h11, 4);
    bus.m_ready_i = 1; cyc = 0;
    start = 1; blen = 4; step(); start = 0;
    repeat (9) step();
    chk("t1_rd_c0", lg_rd[0], 0);
    for (int c = 1; c <= 4; c++) chk("t1_rd", lg_rd[c], 1);
    chk("t1_rd_c5", lg_rd[5], 0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_pop", lg_pop[3+i], 1);
      chk("t1_data", lg_data[3+i], 32'h11 + i);
      chk("t1_last", lg_last[3+i], (i == 3));
    end
    chk("t1_done_c6", lg_done[6], 0);
    chk("t1_done_c7", lg_done[7], 1);
    chk("t1_abt_c7", lg_abt[7], 0);
    chk("t1_busy_c8", lg_busy[8], 0);

    // len=6, ready toggling 1,0,0,1
    fq.delete(); load('h200, 6);
    pat = 4'b1001; cyc = 0;
    bus.m_ready_i = pat[0]; start = 1; blen = 6; step(); start = 0;
    for (int i = 1; i < 40; i++) begin
      bus.m_ready_i = pat[cyc % 4];
      step();
    end
    chk("t2_pops", count_log(1, 0, 39), 6);
    chk("t2_done", count_log(3, 0, 39), 1);
    k = 0;
    for (int i = 0; i < 40; i++)
      if (lg_pop[i]) begin chk("t2_order", lg_data[i], 32'h200 + k); k++; end

    // len=3, FIFO empty for 5 cycles after start
    fq.delete(); load('h30, 3);
    bus.m_ready_i = 1; cyc = 0;
    start = 1; blen = 3; step(); start = 0;
    for (int i = 1; i < 20; i++) begin
      force_empty = (cyc >= 1 && cyc <= 5);
      step();
    end
    force_empty = 0;
    chk("t3_no_rd", count_log(0, 0, 5), 0);
    chk("t3_rd_c6", lg_rd[6], 1);
    chk("t3_done", count_log(3, 0, 19), 1);
    chk("t3_pops", count_log(1, 0, 19), 3);

    // len=0
    fq.delete(); load('h50, 2);
    cyc = 0; start = 1; blen = 0; step(); start = 0;
    repeat (5) step();
    chk("t4_done_c1", lg_done[1], 1);
    chk("t4_abt_c1", lg_abt[1], 0);
    chk("t4_busy_c2", lg_busy[2], 0);
    chk("t4_no_rd", count_log(0, 0, 5), 0);
    chk("t4_no_valid", count_log(4, 0, 5), 0);

    // len=8, abort after 3 handshakes
    fq.delete(); load('h400, 8);
    cyc = 0; pc = 0; ka = -1;
    bus.m_ready_i = 1; start = 1; blen = 8; step(); start = 0;
    for (int i = 1; i < 40; i++) begin
      abort = (pc == 3 && ka < 0);
      if (abort) ka = cyc;
      bus.m_ready_i = !abort;
      step();
      if (lg_pop[cyc-1]) pc++;
    end
    abort = 0; bus.m_ready_i = 1;
    chk("t5_abort_seen", (ka >= 0), 1);
    if (ka >= 0 && ka < 60) begin
      chk("t5_valid_after", lg_valid[ka+1], 0);
      chk("t5_done", lg_done[ka+1], 1);
      chk("t5_aborted", lg_abt[ka+1], 1);
      chk("t5_idle", lg_busy[ka+2], 0);
    end
    chk("t5_no_last", count_log(2, 0, 39), 0);
    chk("t5_pops", count_log(1, 0, 39), 3);

    // reset mid-burst, then len=2
    fq.delete(); load('h500, 5);
    cyc = 0; start = 1; blen = 5; step(); start = 0;
    repeat (3) step();
    rst_n = 0;
    repeat (2) step();
    chk("t6_rst_rd", lg_rd[4] | lg_rd[5], 0);
    chk("t6_rst_busy", lg_busy[4] | lg_busy[5], 0);
    chk("t6_rst_valid", lg_valid[4] | lg_valid[5], 0);
    rst_n = 1;
    step();
    fq.delete(); load('h600, 2);
    cyc = 0; start = 1; blen = 2; step(); start = 0;
    repeat (9) step();
    k = 0;
    for (int i = 0; i < 10; i++)
      if (lg_pop[i]) begin
        chk("t6_data", lg_data[i], 32'h600 + k);
        chk("t6_last", lg_last[i], (k == 1));
        k++;
      end
    chk("t6_pops", k, 2);
    chk("t6_done", count_log(3, 0, 9), 1);
    chk("t6_abt", count_log(2, 0, 9), 1);

    // randomized traffic
    fq.delete();
    for (int i = 0; i < 4000; i++) begin
      start         = ($urandom % 4) == 0;
      blen          = LW'($urandom % 12);
      abort         = ($urandom % 50) == 0;
      bus.m_ready_i = ($urandom % 10) < 7;
      force_empty   = ($urandom % 5) == 0;
      rst_n         = !(i >= 2000 && i < 2002);
      if (fq.size() < 4) fq.push_back(DW'($urandom));
      step();
    end
    start = 0; abort = 0; rst_n = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Single-clock read-side controller that drains a fixed-length burst from the synchronous FIFO's read port and presents it as a valid/ready stream with last-word marking. It drives the FIFO's `rd`/`oe` pins and absorbs the FIFO's one-cycle read latency through a 2-entry output buffer. Reads are credit-limited, so no word is lost under downstream backpressure. It sits directly downstream of the FIFO, in the FIFO read-clock domain.

## Interface
- `DATA_WIDTH`, 18: FIFO word width.
- `LEN_WIDTH`, 11: burst-length width; maximum burst is 2^LEN_WIDTH-1.

- `clk_i` in 1: the single clock, equal to the FIFO read clock.
- `rst_n_i` in 1: reset. Asynchronous assert, active-low.
- `start_i` in 1: burst request. Sampled only in IDLE.
- `burst_len_i` in LEN_WIDTH: number of words. Sampled with `start_i`.
- `abort_i` in 1: terminates the burst in progress.
- `fifo_empty_i` in 1: high when the FIFO has no readable word.
- `fifo_rd_o` out 1: FIFO read strobe.
- `fifo_oe_o` out 1: FIFO output enable.
- `fifo_data_i` in DATA_WIDTH: FIFO data output.
- `m_valid_o` out 1: stream valid.
- `m_ready_i` in 1: stream ready.
- `m_data_o` out DATA_WIDTH: stream data.
- `m_last_o` out 1: marks the final word of the burst.
- `busy_o` out 1: high when state is not IDLE.
- `done_o` out 1: one-cycle completion pulse.
- `aborted_o` out 1: valid with `done_o`; high if the burst ended by abort.

## Operation
**States**
- IDLE -> RUN: on `start_i` with `burst_len_i` ≠ 0. The length is latched.
- IDLE -> DONE: on `start_i` with `burst_len_i` = 0.
- RUN -> DRAIN: on the cycle the final read is issued (issued count reaches len).
- DRAIN -> DONE: on the handshake of the final word.
- RUN or DRAIN -> DONE: on `abort_i`.
- DONE -> IDLE: unconditionally on the next cycle.
- `start_i` is ignored outside IDLE.

**Credit rule**
- occ = buffer occupancy (0..2).
- infl = read issued in the previous cycle (0/1).
- pop = `m_valid_o` & `m_ready_i`.
- `fifo_rd_o` = state==RUN & !`fifo_empty_i` & issued<len & (occ+infl-pop) < 2.
- `fifo_rd_o` is combinational; the `m_ready_i`->`fifo_rd_o` path is accepted.

**Data path**
- `fifo_data_i` is valid in the cycle after `fifo_rd_o`. It is pushed into the buffer at the end of that cycle.
- A read issued while `fifo_empty_i` is low is always accepted by the FIFO.
- The buffer is a 2-entry FIFO. `m_data_o` is the head entry; `m_valid_o` = occ ≠ 0.
- A push and a pop in the same cycle leave occ unchanged.
- Once `m_valid_o` is high, `m_data_o` and `m_last_o` stay stable until the handshake.

**Counters**
- issued and sent are LEN_WIDTH bits each and clear on leaving IDLE. They never wrap, since both stay ≤ len.
- `m_last_o` = `m_valid_o` & (sent == len-1).

**Outputs**
- `fifo_oe_o` = state ≠ IDLE.
- `done_o` is high only in DONE.
- `aborted_o` is high in DONE if entry to DONE was by abort; otherwise low.

**Abort**
- No further reads are issued.
- The buffer is flushed; `m_valid_o` is low from the next cycle.
- Any in-flight FIFO word is discarded.
- `m_last_o` is never asserted for an aborted burst.

## Timing
- Reset values of all outputs are 0: `fifo_rd_o`, `fifo_oe_o`, `m_valid_o`, `m_data_o`, `m_last_o`, `busy_o`, `done_o`, `aborted_o`. State = IDLE; occ, infl and counters = 0.
- With `start_i` at cycle 0: RUN at cycle 1 and the first `fifo_rd_o` at cycle 1 if the FIFO is non-empty. The first `m_valid_o` is at cycle 3.
- With `m_ready_i` held high and the FIFO non-empty, throughput is 1 word per cycle. For a burst of N, the last handshake is at cycle N+2 and `done_o` at cycle N+3.
- With `m_ready_i` low, at most 2 reads are outstanding or buffered; `fifo_rd_o` then stays low.
- Empty mid-burst: `fifo_rd_o` stays low while `fifo_empty_i` is high, and RUN holds indefinitely.
- Abort and final handshake in the same cycle: abort wins and `aborted_o` = 1.
- Reset mid-burst: the state machine returns to IDLE immediately. Words already read from the FIFO are lost.

## Test plan
- Len=4, FIFO pre-loaded with 0x11..0x14, ready held high: `fifo_rd_o` at cycles 1–4, data 0x11..0x14 on cycles 3–6. `m_last_o` on 0x14 only, `done_o` at cycle 7, `aborted_o`=0.
- Len=6, ready toggling 1,0,0,1: no word lost or duplicated, occ never exceeds 2. `fifo_rd_o` low whenever occ+infl-pop = 2.
- Len=3 with `fifo_empty_i` high for 5 cycles after start: no reads in that window; words then stream in order and `done_o` fires once.
- Len=0: `done_o` the cycle after start, `fifo_rd_o` and `m_valid_o` never high.
- Len=8 with `abort_i` after 3 handshakes: `m_valid_o` low next cycle, `done_o`=1 with `aborted_o`=1, no `m_last_o`, state IDLE one cycle later.
- `rst_n_i` low mid-burst, then a new len=2 burst: all outputs 0 during reset; the new burst completes normally with `m_last_o` on its second word.
